ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes the A/B operand values and a decoded mul/div opcode from ID/EX and computes 32x32 products and 32/32 quotient/remainder pairs over 34 cycles. Results go into architectural HI/LO registers. While a result is outstanding it drives a stall that holds ID/EX, through that register's enable, whenever the instruction in EX needs the unit or HI/LO.

---
 rtl/ex_muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32x32 multiply / 32/32 divide unit for the EX stage.
// Results go to the architectural HI/LO registers. While an operation is in
// flight, the stall output holds ID/EX whenever the instruction in EX needs
// this unit or HI/LO.
//
// Handshake: a request is presented with start=1 and a decoded op. It is
// consumed at the rising edge where the unit is IDLE. A request presented
// while busy is not consumed. In that case stall=1 freezes ID/EX, so the same
// request is re-presented until the unit returns to IDLE.
//
// Latency: accept edge E0, then 32 RUN cycles, then a two-cycle FIX. The
// first FIX cycle applies sign/special-case correction. The second FIX cycle
// commits HI/LO at edge E0+34, and done is high for the cycle after that edge.
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hilo_rd,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [1:0]  dbgState
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  count;
   logic        fixPhase;   // 0: correct signs into acc, 1: commit acc to HI/LO
   logic        divMode;
   logic        negQuo;     // negate product (mul) or quotient (div)
   logic        negRem;
   logic        divZero;
   logic [31:0] aOrig;      // dividend as presented, returned in HI on divide-by-zero
   logic [31:0] opnd;       // multiplicand or divisor magnitude
   logic [63:0] acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

   logic        isMul;
   logic        isDiv;
   logic        isSigned;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic [32:0] mulSum;
   logic [32:0] divShift;
   logic [33:0] divDiff;
   logic [63:0] stepAcc;
   logic [63:0] fixAcc;

   assign busy     = (state != IDLE);
   assign stall    = busy & (start | hilo_rd);
   assign dbgState = state;

   // Decode the request and form operand magnitudes for signed ops.
   always_comb begin
      isMul    = (op == OP_MULT) || (op == OP_MULTU);
      isDiv    = (op == OP_DIV)  || (op == OP_DIVU);
      isSigned = (op == OP_MULT) || (op == OP_DIV);
      aMag     = (isSigned && a[31]) ? (~a + 32'd1) : a;
      bMag     = (isSigned && b[31]) ? (~b + 32'd1) : b;
   end

   // One iteration: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      mulSum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
      divShift = {acc[63:32], acc[31]};
      divDiff  = {1'b0, divShift} - {2'b00, opnd};
      stepAcc  = {mulSum, acc[31:1]};
      if (divMode) begin
         if (divDiff[33]) begin
            stepAcc = {divShift[31:0], acc[30:0], 1'b0};
         end else begin
            stepAcc = {divDiff[31:0], acc[30:0], 1'b1};
         end
      end
   end

   // Sign correction and the divide-by-zero override applied in the first FIX cycle.
   always_comb begin
      fixAcc = negQuo ? (~acc + 64'd1) : acc;
      if (divMode) begin
         fixAcc[63:32] = negRem ? (~acc[63:32] + 32'd1) : acc[63:32];
         fixAcc[31:0]  = negQuo ? (~acc[31:0] + 32'd1) : acc[31:0];
         if (divZero) begin
            fixAcc = {aOrig, 32'hFFFFFFFF};
         end
      end
   end

   // Control FSM plus the datapath and HI/LO registers, all with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= 5'd0;
         fixPhase <= 1'b0;
         divMode  <= 1'b0;
         negQuo   <= 1'b0;
         negRem   <= 1'b0;
         divZero  <= 1'b0;
         aOrig    <= 32'd0;
         opnd     <= 32'd0;
         acc      <= 64'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (isMul || isDiv)) begin
                  divMode  <= isDiv;
                  negQuo   <= isSigned & (a[31] ^ b[31]);
                  negRem   <= isSigned & a[31] & isDiv;
                  divZero  <= isDiv & (b == 32'd0);
                  aOrig    <= a;
                  opnd     <= isDiv ? bMag : aMag;
                  acc      <= {32'd0, (isDiv ? aMag : bMag)};
                  count    <= 5'd0;
                  fixPhase <= 1'b0;
                  state    <= RUN;
               end else if (start && (op == OP_MTHI)) begin
                  hi <= a;
               end else if (start && (op == OP_MTLO)) begin
                  lo <= a;
               end
            end
            RUN: begin
               acc   <= stepAcc;
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state    <= FIX;
                  fixPhase <= 1'b0;
               end
            end
            FIX: begin
               if (!fixPhase) begin
                  acc      <= fixAcc;
                  fixPhase <= 1'b1;
               end else begin
                  hi       <= acc[63:32];
                  lo       <= acc[31:0];
                  done     <= 1'b1;
                  fixPhase <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: a driver issues requests and pushes the expected
// {hi,lo} into a queue; a monitor on the falling edge checks busy/stall/done
// timing every cycle and pops/compares whenever done is presented.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hilo_rd;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;
   logic [1:0]  dbgState;

   ex_muldiv_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hilo_rd  (hilo_rd),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .stall    (stall),
      .dbgState (dbgState)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];
   logic [31:0] expHi = 32'd0;
   logic [31:0] expLo = 32'd0;
   bit          haveAcc = 1'b0;
   int          lastAcc = 0;
   bit          monEn = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Reference model: plain arithmetic on the architectural definition.
   function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, q, r, p;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         3'd1: begin p = sx * sy; return p; end
         3'd2: return ux * uy;
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            return {x % y, x / y};
         end
         default: return 64'd0;
      endcase
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin : mon
      int          d;
      bit          eBusy;
      bit          eDone;
      logic [63:0] r;
      if (monEn && rst_n) begin
         d     = cyc - lastAcc;
         eBusy = haveAcc && (d >= 0) && (d < 34);
         eDone = haveAcc && (d == 34);
         check("busy", busy, eBusy);
         check("stall", stall, eBusy && (start || hilo_rd));
         check("done", done, eDone);
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL done_without_request t=%0t actual=done required=no_done", $time);
            end else begin
               r     = exp_q.pop_front();
               expHi = r[63:32];
               expLo = r[31:0];
            end
         end else if (eDone && exp_q.size() != 0) begin
            r = exp_q.pop_front();
            expHi = r[63:32];
            expLo = r[31:0];
         end
         check("hi", hi, expHi);
         check("lo", lo, expLo);
      end
   end

   // driver tasks (inputs change 1 time unit after the rising edge)
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      haveAcc = 1'b0;
      exp_q.delete();
      expHi   = 32'd0;
      expLo   = 32'd0;
      @(posedge clk);
      #1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      bit wasIdle;
      bit ok;
      ok    = 1'b0;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      for (int w = 0; w < 80; w++) begin
         wasIdle = !busy;
         @(posedge clk);
         #1;
         if (wasIdle) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept", ok, 1'b1);
      if (ok) begin
         if (o >= 3'd1 && o <= 3'd4) begin
            exp_q.push_back(refModel(o, x, y));
            haveAcc = 1'b1;
            lastAcc = cyc;
         end else if (o == 3'd5) begin
            expHi = x;
         end else if (o == 3'd6) begin
            expLo = x;
         end
      end
      start = 1'b0;
      op    = 3'd0;
   endtask

   task automatic waitIdle();
      for (int w = 0; w < 80; w++) begin
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      check("idle_wait", busy, 1'b0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  o;
      rst_n   = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      a       = 32'd0;
      b       = 32'd0;
      hilo_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      doReset();
      monEn = 1'b1;

      // reset in the middle of RUN discards the result
      issue(3'd2, 32'd3, 32'd5);
      idle(9);
      doReset();
      hilo_rd = 1'b1;
      idle(1);
      hilo_rd = 1'b0;
      idle(2);

      // directed arithmetic cases, back to back
      issue(3'd1, 32'hFFFFFFFE, 32'd7);
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      issue(3'd4, 32'd7, 32'd2);
      issue(3'd4, 32'h12345678, 32'd0);
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      waitIdle();
      idle(2);

      // interlock: MFHI/MFLO raised mid-operation, plus a second request held off
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      idle(4);
      hilo_rd = 1'b1;
      idle(6);
      issue(3'd3, 32'd100, 32'hFFFFFFFD);
      hilo_rd = 1'b0;
      waitIdle();
      idle(1);

      // moves: MTLO in IDLE, MTHI held while busy
      issue(3'd6, 32'hDEADBEEF, 32'd0);
      idle(1);
      issue(3'd1, 32'h7FFFFFFF, 32'h80000000);
      issue(3'd5, 32'hCAFEF00D, 32'd0);
      idle(2);

      // op none is ignored
      issue(3'd0, 32'h11111111, 32'd1);
      issue(3'd7, 32'h22222222, 32'd2);
      idle(2);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         o = 3'($urandom_range(1, 6));
         x = $urandom();
         y = $urandom();
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            2: begin x = 32'($urandom_range(0, 20)); y = 32'($urandom_range(1, 5)); end
            3: y = 32'($urandom_range(0, 3)) - 32'd2;
            default: ;
         endcase
         hilo_rd = 1'($urandom_range(0, 1));
         issue(o, x, y);
         idle($urandom_range(0, 3));
      end
      hilo_rd = 1'b0;
      waitIdle();
      idle(3);
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
